// File: rtl/mem_access_stage_pkg.sv
// Shared types for the MEM stage: access-size encoding, FSM states, lane helper.
package mem_access_stage_pkg;

    localparam logic [1:0] SZ_NONE = 2'b00;
    localparam logic [1:0] SZ_B    = 2'b01;
    localparam logic [1:0] SZ_H    = 2'b10;
    localparam logic [1:0] SZ_W    = 2'b11;

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    // Little-endian byte enables; unused low address bits are ignored.
    function automatic logic [3:0] byte_en(
        input logic [1:0] size,
        input logic [1:0] a
    );
        logic [3:0] be;
        be = 4'b0000;
        unique case (size)
            SZ_B:    be = 4'b0001 << a;
            SZ_H:    be = a[1] ? 4'b1100 : 4'b0011;
            SZ_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory req/ack port between the MEM stage (master) and memory (slave).
interface mem_access_stage_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output ack, rdata
    );

endinterface

// File: rtl/mem_access_stage_load_align.sv
// Picks the addressed lane(s) of a read word and sign/zero-extends them.
module load_align
    import mem_access_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] value
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rdata[7:0];
        unique case (addr)
            2'd0:    lane_b = rdata[7:0];
            2'd1:    lane_b = rdata[15:8];
            2'd2:    lane_b = rdata[23:16];
            default: lane_b = rdata[31:24];
        endcase
        lane_h = addr[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        value = rdata;
        unique case (size)
            SZ_B:    value = {{24{~uns & lane_b[7]}}, lane_b};
            SZ_H:    value = {{16{~uns & lane_h[15]}}, lane_h};
            default: value = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: req/ack loads and stores, stall generation, MEM/WB register.
// Optional MEM_MISALIGN_TRAP_EN: trap on misaligned half/word instead of forcing alignment.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int REG_AW = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [REG_AW-1:0]   in_dest,
    input  logic                in_regwrite,
    input  logic                in_memtoreg,
    input  logic [1:0]          in_memread,
    input  logic [1:0]          in_memwrite,
    input  logic                in_load_uns,
    input  logic [DATA_W-1:0]   in_alu_result,
    input  logic [DATA_W-1:0]   in_store_data,
    mem_access_stage_if.master  dm,
    output logic                mem_stall,
    output logic                wb_valid,
    output logic [REG_AW-1:0]   wb_dest,
    output logic                wb_regwrite,
    output logic [DATA_W-1:0]   wb_data,
    output logic                misalign_trap
);

    state_t      state;
    logic        is_store;
    logic [1:0]  size;
    logic [1:0]  a_lo;
    logic        access;
    logic        misaligned;
    logic        go;
    logic        capture;
    logic [31:0] load_value;

    assign is_store = in_memwrite != SZ_NONE;
    assign size     = is_store ? in_memwrite : in_memread;
    assign a_lo     = in_alu_result[1:0];
    assign access   = in_valid & (size != SZ_NONE);

`ifdef MEM_MISALIGN_TRAP_EN
    assign misaligned = access
                      & (((size == SZ_H) & a_lo[0])
                      |  ((size == SZ_W) & (a_lo != 2'b00)));
`else
    assign misaligned = 1'b0;
`endif

    assign go      = access & ~misaligned;
    assign capture = ~go | dm.ack;

    // WAIT keeps the request up even if upstream misbehaves.
    assign dm.req  = ~rst & (go | (state == WAIT));
    assign dm.we   = is_store;
    assign dm.addr = {in_alu_result[ADDR_W-1:2], 2'b00};
    assign dm.be   = byte_en(size, a_lo);

    always_comb begin
        dm.wdata = in_store_data;
        unique case (in_memwrite)
            SZ_B:    dm.wdata = {4{in_store_data[7:0]}};
            SZ_H:    dm.wdata = {2{in_store_data[15:0]}};
            default: dm.wdata = in_store_data;
        endcase
    end

    assign mem_stall = dm.req & ~dm.ack;

    load_align u_load_align (
        .rdata (dm.rdata),
        .addr  (a_lo),
        .size  (in_memread),
        .uns   (in_load_uns),
        .value (load_value)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            wb_valid      <= 1'b0;
            wb_dest       <= '0;
            wb_regwrite   <= 1'b0;
            wb_data       <= '0;
            misalign_trap <= 1'b0;
        end else begin
            unique case (state)
                IDLE:    if (go & ~dm.ack) state <= WAIT;
                default: if (dm.ack) state <= IDLE;
            endcase
            if (capture) begin
                wb_valid      <= in_valid;
                wb_dest       <= in_dest;
                wb_regwrite   <= in_valid & in_regwrite
                               & ~is_store & ~misaligned;
                wb_data       <= in_memtoreg ? load_value
                                             : in_alu_result;
                misalign_trap <= misaligned;
            end else begin
                wb_valid      <= 1'b0;
                wb_regwrite   <= 1'b0;
                misalign_trap <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage with a hand-driven memory port.
module tb_mem_access_stage;

    import mem_access_stage_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [4:0]  in_dest;
    logic        in_regwrite;
    logic        in_memtoreg;
    logic [1:0]  in_memread;
    logic [1:0]  in_memwrite;
    logic        in_load_uns;
    logic [31:0] in_alu_result;
    logic [31:0] in_store_data;
    logic        mem_stall;
    logic        wb_valid;
    logic [4:0]  wb_dest;
    logic        wb_regwrite;
    logic [31:0] wb_data;
    logic        misalign_trap;

    int n_checks;
    int n_errors;

    mem_access_stage_if dm ();

    mem_access_stage dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_dest       (in_dest),
        .in_regwrite   (in_regwrite),
        .in_memtoreg   (in_memtoreg),
        .in_memread    (in_memread),
        .in_memwrite   (in_memwrite),
        .in_load_uns   (in_load_uns),
        .in_alu_result (in_alu_result),
        .in_store_data (in_store_data),
        .dm            (dm.master),
        .mem_stall     (mem_stall),
        .wb_valid      (wb_valid),
        .wb_dest       (wb_dest),
        .wb_regwrite   (wb_regwrite),
        .wb_data       (wb_data),
        .misalign_trap (misalign_trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h",
                     tag, got, exp);
        end
    endtask

    task automatic drive(input logic       v,
                         input logic [4:0] d,
                         input logic       rw,
                         input logic       m2r,
                         input logic [1:0] rd,
                         input logic [1:0] wr,
                         input logic       uns,
                         input logic [31:0] alu,
                         input logic [31:0] sd);
        in_valid      = v;
        in_dest       = d;
        in_regwrite   = rw;
        in_memtoreg   = m2r;
        in_memread    = rd;
        in_memwrite   = wr;
        in_load_uns   = uns;
        in_alu_result = alu;
        in_store_data = sd;
    endtask

    task automatic mem(input logic a, input logic [31:0] r);
        dm.ack   = a;
        dm.rdata = r;
    endtask

    // Inputs change #1 after posedge; outputs sampled at the following negedge
    // (combinational) and #1 after the next posedge (registered).
    task automatic mid();
        @(negedge clk);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        drive(1'b1, 5'd1, 1'b1, 1'b1, SZ_W, SZ_NONE, 1'b0,
              32'h100, 32'h0);
        mem(1'b0, 32'h0);

        // reset: request suppressed, MEM/WB cleared
        mid();
        check("rst_req", {31'b0, dm.req}, 32'd0);
        step();
        step();
        check("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        check("rst_wb_rw", {31'b0, wb_regwrite}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_wb_dest", {27'b0, wb_dest}, 32'd0);
        check("rst_trap", {31'b0, misalign_trap}, 32'd0);
        rst = 1'b0;

        // 1: lw zero-wait
        drive(1'b1, 5'd3, 1'b1, 1'b1, SZ_W, SZ_NONE, 1'b0,
              32'h100, 32'h0);
        mem(1'b1, 32'hDEADBEEF);
        mid();
        check("lw_req", {31'b0, dm.req}, 32'd1);
        check("lw_we", {31'b0, dm.we}, 32'd0);
        check("lw_addr", dm.addr, 32'h100);
        check("lw_be", {28'b0, dm.be}, 32'hF);
        check("lw_stall", {31'b0, mem_stall}, 32'd0);
        step();
        check("lw_wb_valid", {31'b0, wb_valid}, 32'd1);
        check("lw_wb_data", wb_data, 32'hDEADBEEF);
        check("lw_wb_rw", {31'b0, wb_regwrite}, 32'd1);
        check("lw_wb_dest", {27'b0, wb_dest}, 32'd3);

        // 2: lb / lbu on lane 3
        drive(1'b1, 5'd4, 1'b1, 1'b1, SZ_B, SZ_NONE, 1'b0,
              32'h103, 32'h0);
        mem(1'b1, 32'h80FF0011);
        mid();
        check("lb_be", {28'b0, dm.be}, 32'h8);
        check("lb_addr", dm.addr, 32'h100);
        step();
        check("lb_wb_data", wb_data, 32'hFFFFFF80);
        in_load_uns = 1'b1;
        step();
        check("lbu_wb_data", wb_data, 32'h00000080);

        // lh / lhu on upper half
        drive(1'b1, 5'd5, 1'b1, 1'b1, SZ_H, SZ_NONE, 1'b0,
              32'h202, 32'h0);
        mem(1'b1, 32'h80017FFF);
        mid();
        check("lh_be", {28'b0, dm.be}, 32'hC);
        step();
        check("lh_wb_data", wb_data, 32'hFFFF8001);
        in_load_uns = 1'b1;
        in_alu_result = 32'h200;
        step();
        check("lhu_lo_wb_data", wb_data, 32'h00007FFF);

        // sb lane 1
        drive(1'b1, 5'd6, 1'b1, 1'b0, SZ_NONE, SZ_B, 1'b0,
              32'h301, 32'h1122335A);
        mem(1'b1, 32'h0);
        mid();
        check("sb_be", {28'b0, dm.be}, 32'h2);
        check("sb_wdata", dm.wdata, 32'h5A5A5A5A);
        check("sb_we", {31'b0, dm.we}, 32'd1);
        step();
        check("sb_wb_rw", {31'b0, wb_regwrite}, 32'd0);

        // 3: sh with three wait states
        drive(1'b1, 5'd7, 1'b1, 1'b0, SZ_NONE, SZ_H, 1'b0,
              32'h102, 32'h1234ABCD);
        mem(1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            mid();
            check("sh_be", {28'b0, dm.be}, 32'hC);
            check("sh_wdata", dm.wdata, 32'hABCDABCD);
            check("sh_stall", {31'b0, mem_stall}, 32'd1);
            step();
            check("sh_wb_valid_stall", {31'b0, wb_valid}, 32'd0);
        end
        dm.ack = 1'b1;
        mid();
        check("sh_req_ack", {31'b0, dm.req}, 32'd1);
        check("sh_stall_ack", {31'b0, mem_stall}, 32'd0);
        step();
        check("sh_wb_valid", {31'b0, wb_valid}, 32'd1);
        check("sh_wb_rw", {31'b0, wb_regwrite}, 32'd0);

        // store wins over load when both sizes set
        drive(1'b1, 5'd8, 1'b1, 1'b1, SZ_W, SZ_W, 1'b0,
              32'h400, 32'hCAFEF00D);
        mem(1'b1, 32'h0);
        mid();
        check("both_we", {31'b0, dm.we}, 32'd1);
        step();
        check("both_wb_rw", {31'b0, wb_regwrite}, 32'd0);

        // 4: ALU op
        drive(1'b1, 5'd9, 1'b1, 1'b0, SZ_NONE, SZ_NONE, 1'b0,
              32'h55, 32'h0);
        mem(1'b0, 32'h0);
        mid();
        check("alu_req", {31'b0, dm.req}, 32'd0);
        check("alu_stall", {31'b0, mem_stall}, 32'd0);
        step();
        check("alu_wb_data", wb_data, 32'h55);
        check("alu_wb_valid", {31'b0, wb_valid}, 32'd1);
        check("alu_wb_rw", {31'b0, wb_regwrite}, 32'd1);

        // bubble input
        in_valid = 1'b0;
        step();
        check("bubble_wb_valid", {31'b0, wb_valid}, 32'd0);
        check("bubble_wb_rw", {31'b0, wb_regwrite}, 32'd0);

        // 5: reset during WAIT
        drive(1'b1, 5'd10, 1'b1, 1'b1, SZ_W, SZ_NONE, 1'b0,
              32'h500, 32'h0);
        mem(1'b0, 32'h0);
        step();
        check("rw_wait_stall", {31'b0, mem_stall}, 32'd1);
        rst = 1'b1;
        mid();
        check("rw_req_rst", {31'b0, dm.req}, 32'd0);
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        mid();
        check("rw_req_after", {31'b0, dm.req}, 32'd0);
        check("rw_wb_valid", {31'b0, wb_valid}, 32'd0);
        check("rw_wb_rw", {31'b0, wb_regwrite}, 32'd0);
        check("rw_wb_data", wb_data, 32'd0);
        check("rw_wb_dest", {27'b0, wb_dest}, 32'd0);

        // 6: misaligned word
        drive(1'b1, 5'd11, 1'b1, 1'b1, SZ_W, SZ_NONE, 1'b0,
              32'h101, 32'h0);
        mem(1'b1, 32'h11223344);
`ifdef MEM_MISALIGN_TRAP_EN
        dm.ack = 1'b0;
        mid();
        check("mis_req", {31'b0, dm.req}, 32'd0);
        check("mis_stall", {31'b0, mem_stall}, 32'd0);
        step();
        check("mis_trap", {31'b0, misalign_trap}, 32'd1);
        check("mis_wb_valid", {31'b0, wb_valid}, 32'd1);
        check("mis_wb_rw", {31'b0, wb_regwrite}, 32'd0);
        in_valid = 1'b0;
        step();
        check("mis_trap_pulse", {31'b0, misalign_trap}, 32'd0);
`else
        mid();
        check("mis_req", {31'b0, dm.req}, 32'd1);
        check("mis_addr", dm.addr, 32'h100);
        check("mis_be", {28'b0, dm.be}, 32'hF);
        step();
        check("mis_trap", {31'b0, misalign_trap}, 32'd0);
        check("mis_wb_data", wb_data, 32'h11223344);
        check("mis_wb_rw", {31'b0, wb_regwrite}, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
